// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with registered bypassed reads and a per-register busy scoreboard
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              stall,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic              wr_ok;
    logic              issue_ok;
    logic              set_new;
    logic              clr_old;
    logic              fwd1;
    logic              fwd2;
    logic [DATA_W-1:0] sel1;
    logic [DATA_W-1:0] sel2;

    // Writes and issues to the hardwired zero register are dropped here, so it never holds data or busy.
    assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign issue_ok = issue_en && !flush && !((ZERO_REG != 0) && (issue_addr == '0));

    // Counter deltas: an issue to a register being written keeps it busy, so that write is not a clear.
    assign set_new = issue_ok && !busy[issue_addr];
    assign clr_old = wr_ok && busy[wr_addr] && !(issue_ok && (issue_addr == wr_addr));

    assign fwd1 = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr1);
    assign fwd2 = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr2);

    always_comb begin
        sel1 = regs[rd_addr1];
        sel2 = regs[rd_addr2];
        if (fwd1) sel1 = wr_data;
        if (fwd2) sel2 = wr_data;
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) sel1 = '0;
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) sel2 = '0;
    end

    assign rd_busy1 = busy[rd_addr1] && !fwd1;
    assign rd_busy2 = busy[rd_addr2] && !fwd2;
    assign stall    = rd_busy1 || rd_busy2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_data1 <= sel1;
            rd_data2 <= sel2;
        end
    end

    // Issue is applied after writeback so a new producer wins over the retiring one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wr_ok)    busy[wr_addr]    <= 1'b0;
            if (issue_ok) busy[issue_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_count <= '0;
        end else if (flush) begin
            busy_count <= '0;
        end else begin
            case ({set_new, clr_old})
                2'b10:   busy_count <= busy_count + 1'b1;
                2'b01:   busy_count <= busy_count - 1'b1;
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the decode-stage register file: configurable width and depth, registered read ports with write-to-read bypass, and a per-register busy scoreboard for RAW hazard detection. Sits in the decode unit. Decode reads operands and issues destinations; writeback writes results and clears busy flags. Produces a stall signal for the hazard/issue logic.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy cleared in the same cycle; 0 = no forwarding

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  registered read data, port 1
rd_data2  out  DATA_W  registered read data, port 2
rd_busy1  out  1  combinational: rd_addr1 is pending a write
rd_busy2  out  1  combinational: rd_addr2 is pending a write
stall  out  1  combinational: rd_busy1 | rd_busy2
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
issue_en  in  1  mark issue_addr busy (destination of issued instruction)
issue_addr  in  ADDR_W  destination register being issued
flush  in  1  synchronous: clear all busy flags (pipeline flush)
busy_count  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (reset=0, async): all registers = 0; all busy flags = 0; rd_data1/2 = 0; busy_count = 0. Reset asserted mid-operation discards all pending state immediately.
- Write: at posedge, if wr_en and not (ZERO_REG and wr_addr==0), regs[wr_addr] <= wr_data.
- Read: 1-cycle latency. At posedge, rd_dataN <= selected value of rd_addrN. Selected value is wr_data when BYPASS and wr_en and wr_addr==rd_addrN and the address is not the hardwired zero register; otherwise regs[rd_addrN] (old value). With ZERO_REG, reads of address 0 always return 0.
- Busy flag per register; next-state priority, highest first:
  1. flush: all flags 0. issue_en in the same cycle is ignored.
  2. issue_en on addr A: busy[A] <= 1. This applies even if wr_en targets A in the same cycle, because a new producer supersedes the retiring one.
  3. wr_en on addr A, no issue to A: busy[A] <= 0.
  4. Issuing to an already-busy register (WAW) is allowed; the flag stays 1.
- ZERO_REG: busy[0] is constant 0, and issue or write to address 0 has no effect.
- rd_busyN = busy[rd_addrN], except forced 0 when BYPASS, wr_en and wr_addr==rd_addrN (result arrives this cycle). With BYPASS=0 the flag is reported as is.
- busy_count equals the popcount of the busy flags and is updated at the same edge as the flags. It is a registered counter (+1 for a new set, -1 for a clear, net 0 for simultaneous set and clear of different registers), not a recomputed popcount. flush sets it to 0. It never exceeds NUM_REGS - ZERO_REG.
- No X propagation: all outputs are defined after reset for any input combination.

Test Plan:
1. Reset, then read addr 4 and addr 31 -> rd_data1=0, rd_data2=0, busy_count=0, stall=0.
2. wr_en addr 5 data 0xDEADBEEF; next cycle read addr 5 -> rd_data1=0xDEADBEEF one cycle after the read address is applied. Same-cycle write+read of addr 5 with data 0x1234 -> rd_data=0x1234 (BYPASS=1) or 0xDEADBEEF (BYPASS=0).
3. Write 0xFFFFFFFF to addr 0 and issue addr 0 -> read addr 0 returns 0, rd_busy=0, busy_count=0 (ZERO_REG=1).
4. Issue addr 7 -> rd_addr1=7 gives rd_busy1=1, stall=1, busy_count=1. Writeback addr 7 data 42 in the same cycle as the read -> stall=0 that cycle (BYPASS=1), rd_data1=42 next cycle, busy_count=0.
5. Same-cycle issue addr 9 and write addr 9 -> busy[9] remains 1, busy_count unchanged from the increment. Issue addrs 1,2,3 then flush together with issue addr 4 -> all flags 0, busy_count=0.
6. Assert reset asynchronously between clock edges with 3 busy registers and nonzero data -> outputs 0 immediately, busy_count=0. After release, reads return 0.
